// File: rtl/pe_inject_ctrl.sv
// ----------------------------------------------------------------------------
// pe_inject_ctrl: streams NUM_FLITS BRAM words into the router local port
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pe_inject_ctrl #(
  parameter int FLIT_W    = 20,
  parameter int ADDR_W    = 5,
  parameter int NUM_FLITS = 30
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              start,
  output logic              bram_en,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [FLIT_W-1:0] bram_dout,
  output logic [FLIT_W-1:0] flit_out,
  output logic              flit_valid,
  input  logic              flit_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   sent_cnt
);

  localparam logic [ADDR_W:0] LAST    = (ADDR_W+1)'(NUM_FLITS);
  localparam logic [ADDR_W:0] LAST_M1 = (ADDR_W+1)'(NUM_FLITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W:0]   rd_cnt;
  logic              inflight;
  logic [FLIT_W-1:0] fifo_mem [2];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        fifo_count;
  logic              push, pop;
  logic [2:0]        occupancy;
  logic              credit;

  assign push       = inflight;
  assign flit_valid = (fifo_count != 2'd0);
  assign pop        = flit_valid && flit_ready;
  assign flit_out   = flit_valid ? fifo_mem[rd_ptr] : '0;
  assign bram_addr  = rd_cnt[ADDR_W-1:0];

  // A head leaving this cycle frees a slot, so a read may issue against it;
  // this keeps one flit per cycle flowing through the two-entry buffer.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight};
  assign credit    = occupancy < (3'd2 + {2'b00, pop});

  always_comb begin
    state_nxt = state;
    bram_en   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if ((rd_cnt < LAST) && credit) bram_en = 1'b1;
        if (bram_en && (rd_cnt == LAST_M1)) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (pop && (sent_cnt == LAST_M1)) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state      <= IDLE;
      rd_cnt     <= '0;
      sent_cnt   <= '0;
      inflight   <= 1'b0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      state    <= state_nxt;
      inflight <= bram_en;
      if ((state == IDLE) && start) begin
        rd_cnt   <= '0;
        sent_cnt <= '0;
      end else begin
        if (bram_en) rd_cnt <= rd_cnt + 1'b1;
        if (pop && (sent_cnt < LAST)) sent_cnt <= sent_cnt + 1'b1;
      end
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Storage only; validity is carried by fifo_count.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bram_dout;
  end

endmodule

`default_nettype wire

// File: tb/tb_pe_inject_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pe_inject_ctrl: directed self-checking bench for pe_inject_ctrl
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_pe_inject_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, ready, start1, ready1;
  logic        bram_en, flit_valid, busy, done;
  logic [4:0]  bram_addr;
  logic [19:0] bram_dout, flit_out;
  logic [5:0]  sent_cnt;
  logic        bram_en1, flit_valid1, busy1, done1;
  logic [4:0]  bram_addr1;
  logic [19:0] bram_dout1, flit_out1;
  logic [5:0]  sent_cnt1;

  logic [19:0] mem [32];

  pe_inject_ctrl #(.FLIT_W(20), .ADDR_W(5), .NUM_FLITS(30)) dut (
    .clk(clk), .RST(rst), .start(start), .bram_en(bram_en), .bram_addr(bram_addr),
    .bram_dout(bram_dout), .flit_out(flit_out), .flit_valid(flit_valid),
    .flit_ready(ready), .busy(busy), .done(done), .sent_cnt(sent_cnt));

  pe_inject_ctrl #(.FLIT_W(20), .ADDR_W(5), .NUM_FLITS(1)) dut1 (
    .clk(clk), .RST(rst), .start(start1), .bram_en(bram_en1), .bram_addr(bram_addr1),
    .bram_dout(bram_dout1), .flit_out(flit_out1), .flit_valid(flit_valid1),
    .flit_ready(ready1), .busy(busy1), .done(done1), .sent_cnt(sent_cnt1));

  always @(posedge clk) if (bram_en)  bram_dout  <= mem[bram_addr];
  always @(posedge clk) if (bram_en1) bram_dout1 <= mem[bram_addr1];

  int tests = 0;
  int fails = 0;

  int s_nfl, s_order_err, s_stable_err, s_ndone, s_nreads, s_addr_err;
  int s_stall_reads, s_first, s_last, s_done_c, s_first_rd, s_post, s_cnt, s_en13;

  function automatic logic [19:0] exp_flit(input int i);
    return {16'(i + 1), 4'hA};
  endfunction

  // Drives one start and collects observations for the calling test to judge.
  // mode 1: ready=1, 2: ready toggles, 3: 10-cycle stall, 4: start re-pulsed.
  task automatic run_stream(input int mode, input int ncyc);
    logic        prev_stall;
    logic [19:0] prev_out;
    s_nfl = 0; s_order_err = 0; s_stable_err = 0; s_ndone = 0; s_nreads = 0;
    s_addr_err = 0; s_stall_reads = 0; s_first = -1; s_last = -1; s_done_c = -1;
    s_first_rd = -1; s_post = 0; s_en13 = -1;
    prev_stall = 1'b0; prev_out = '0;
    @(posedge clk); #1;
    start = 1'b1;
    ready = (mode == 2) ? 1'b0 : 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      start = (mode == 4) && (c == 5 || c == 33);
      case (mode)
        2:       ready = (c % 2 == 1);
        3:       ready = !(c >= 4 && c <= 13);
        default: ready = 1'b1;
      endcase
      @(negedge clk);
      if (prev_stall && (flit_valid !== 1'b1 || flit_out !== prev_out)) s_stable_err++;
      if (mode == 3 && c == 13) s_en13 = int'(bram_en);
      if (bram_en) begin
        if (s_done_c >= 0) s_post++;
        if (s_first_rd < 0) s_first_rd = c;
        if (bram_addr !== 5'(s_nreads)) s_addr_err++;
        s_nreads++;
        if (!ready) s_stall_reads++;
      end
      if (flit_valid && ready) begin
        if (flit_out !== exp_flit(s_nfl)) s_order_err++;
        if (s_first < 0) s_first = c;
        s_last = c;
        s_nfl++;
      end
      if (done) begin
        s_ndone++;
        s_done_c = c;
      end
      prev_stall = flit_valid && !ready;
      prev_out   = flit_out;
    end
    s_cnt = int'(sent_cnt);
    start = 1'b0;
    ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; ready = 1'b1; start1 = 1'b0; ready1 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++; if (bram_en !== 1'b0)    begin fails++; $display("FAIL reset_bram_en: got %0b expected 0", bram_en); end
    tests++; if (flit_valid !== 1'b0) begin fails++; $display("FAIL reset_flit_valid: got %0b expected 0", flit_valid); end
    tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL reset_busy_done: got %0b%0b expected 00", busy, done); end
    tests++; if (sent_cnt !== 6'd0 || bram_addr !== 5'd0) begin fails++; $display("FAIL reset_counts: got cnt=%0d addr=%0d expected 0,0", sent_cnt, bram_addr); end
    tests++; if (bram_en1 !== 1'b0 || flit_valid1 !== 1'b0) begin fails++; $display("FAIL reset_dut1: got en=%0b valid=%0b expected 0,0", bram_en1, flit_valid1); end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_full_speed();
    run_stream(1, 40);
    tests++; if (s_first_rd != 1) begin fails++; $display("FAIL full_first_read: got cycle %0d expected 1", s_first_rd); end
    tests++; if (s_nreads != 30 || s_addr_err != 0) begin fails++; $display("FAIL full_reads: got %0d reads, %0d addr errors expected 30, 0", s_nreads, s_addr_err); end
    tests++; if (s_first != 3 || s_last != 32) begin fails++; $display("FAIL full_flit_window: got c%0d..c%0d expected c3..c32", s_first, s_last); end
    tests++; if (s_nfl != 30 || s_order_err != 0) begin fails++; $display("FAIL full_flits: got %0d flits, %0d data errors expected 30, 0", s_nfl, s_order_err); end
    tests++; if (s_done_c != 33 || s_ndone != 1) begin fails++; $display("FAIL full_done: got c%0d x%0d expected c33 x1", s_done_c, s_ndone); end
    tests++; if (s_cnt != 30) begin fails++; $display("FAIL full_sent_cnt: got %0d expected 30", s_cnt); end
  endtask

  task automatic test_toggle_ready();
    run_stream(2, 90);
    tests++; if (s_nfl != 30 || s_order_err != 0) begin fails++; $display("FAIL toggle_flits: got %0d flits, %0d data errors expected 30, 0", s_nfl, s_order_err); end
    tests++; if (s_stable_err != 0) begin fails++; $display("FAIL toggle_stable: got %0d unstable stalls expected 0", s_stable_err); end
    tests++; if (s_ndone != 1 || s_cnt != 30) begin fails++; $display("FAIL toggle_done: got done x%0d cnt=%0d expected x1, 30", s_ndone, s_cnt); end
  endtask

  task automatic test_stall();
    run_stream(3, 55);
    tests++; if (s_stall_reads > 2) begin fails++; $display("FAIL stall_reads: got %0d reads during stall expected at most 2", s_stall_reads); end
    tests++; if (s_en13 != 0) begin fails++; $display("FAIL stall_bram_en: got %0d at end of stall expected 0", s_en13); end
    tests++; if (s_nfl != 30 || s_order_err != 0 || s_stable_err != 0) begin fails++; $display("FAIL stall_flits: got %0d flits, %0d data, %0d stability errors expected 30, 0, 0", s_nfl, s_order_err, s_stable_err); end
    tests++; if (s_done_c != 43 || s_ndone != 1) begin fails++; $display("FAIL stall_done: got c%0d x%0d expected c43 x1", s_done_c, s_ndone); end
  endtask

  task automatic test_start_ignored();
    run_stream(4, 60);
    tests++; if (s_nfl != 30 || s_order_err != 0) begin fails++; $display("FAIL restart_flits: got %0d flits, %0d data errors expected 30, 0", s_nfl, s_order_err); end
    tests++; if (s_ndone != 1 || s_done_c != 33) begin fails++; $display("FAIL restart_done: got c%0d x%0d expected c33 x1", s_done_c, s_ndone); end
    tests++; if (s_post != 0 || s_cnt != 30) begin fails++; $display("FAIL restart_after_done: got %0d reads, cnt=%0d expected 0, 30", s_post, s_cnt); end
  endtask

  task automatic test_reset_abort();
    bit hit = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; ready = 1'b1;
    for (int c = 1; c <= 40 && !hit; c++) begin
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      if (sent_cnt == 6'd12) hit = 1'b1;
    end
    tests++; if (!hit) begin fails++; $display("FAIL abort_reach12: got sent_cnt=%0d expected 12 within 40 cycles", sent_cnt); end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    tests++; if ({bram_en, flit_valid, busy, done} !== 4'b0000) begin fails++; $display("FAIL abort_flags: got en,valid,busy,done=%b expected 0000", {bram_en, flit_valid, busy, done}); end
    tests++; if (sent_cnt !== 6'd0 || bram_addr !== 5'd0 || flit_out !== 20'd0) begin fails++; $display("FAIL abort_values: got cnt=%0d addr=%0d flit=%h expected 0,0,0", sent_cnt, bram_addr, flit_out); end
    run_stream(1, 40);
    tests++; if (s_nfl != 30 || s_order_err != 0 || s_first != 3) begin fails++; $display("FAIL abort_rerun: got %0d flits, %0d errors, first c%0d expected 30, 0, c3", s_nfl, s_order_err, s_first); end
    tests++; if (s_done_c != 33) begin fails++; $display("FAIL abort_rerun_done: got c%0d expected c33", s_done_c); end
  endtask

  task automatic test_single_flit();
    int nreads = 0, nfl = 0, fl_c = -1, done_c = -1, ndone = 0, addr_err = 0, data_err = 0;
    @(posedge clk); #1;
    start1 = 1'b1; ready1 = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1 start1 = 1'b0;
      @(negedge clk);
      if (bram_en1) begin nreads++; if (bram_addr1 !== 5'd0) addr_err++; end
      if (flit_valid1 && ready1) begin nfl++; fl_c = c; if (flit_out1 !== exp_flit(0)) data_err++; end
      if (done1) begin ndone++; done_c = c; end
    end
    tests++; if (nreads != 1 || addr_err != 0) begin fails++; $display("FAIL single_reads: got %0d reads, %0d addr errors expected 1, 0", nreads, addr_err); end
    tests++; if (nfl != 1 || fl_c != 3 || data_err != 0) begin fails++; $display("FAIL single_flit: got %0d flits at c%0d, %0d data errors expected 1 at c3, 0", nfl, fl_c, data_err); end
    tests++; if (ndone != 1 || done_c != 4) begin fails++; $display("FAIL single_done: got c%0d x%0d expected c4 x1", done_c, ndone); end
    tests++; if (sent_cnt1 !== 6'd1) begin fails++; $display("FAIL single_sent_cnt: got %0d expected 1", sent_cnt1); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = exp_flit(i);
    test_reset();
    test_full_speed();
    test_toggle_ready();
    test_stall();
    test_start_ignored();
    test_reset_abort();
    test_single_flit();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
